// File: rtl/global_reset_pkg.sv
// Purpose: shared types and defaults for the global reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the sequencer state enum, the default timing constants and the
// helper that sizes the shared cycle counter.
package global_reset_pkg;

    // PLL lock stabilisation time, release stagger and soft-reset hold, in clock cycles.
    localparam int DEF_STABLE_CYCLES    = 1024;
    localparam int DEF_STAGGER_CYCLES   = 16;
    localparam int DEF_SOFT_HOLD_CYCLES = 64;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABILIZE = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SOFT_HOLD = 3'd4
    } seqState_t;

    // The counter never exceeds (longest interval - 1). The release window
    // spans three stagger intervals, so it competes with the other two
    // parameters for the largest span.
    function automatic int counterWidth(input int stableCycles,
                                        input int staggerCycles,
                                        input int softHoldCycles);
        int longest;
        longest = stableCycles;
        if (3 * staggerCycles > longest) longest = 3 * staggerCycles;
        if (softHoldCycles > longest) longest = softHoldCycles;
        if (longest < 2) longest = 2;
        return $clog2(longest);
    endfunction

endpackage

// File: rtl/reset_lock_sync.sv
// Purpose: two-flop synchronizer bringing the asynchronous PLL lock flag into the clock domain.
// Latency: input sampled at edge N is visible on syncOut after edge N+1.
// Backpressure: none; free-running.
//
// Ports:
//   clk      - sampling clock
//   rstN     - asynchronous active-low clear of both flops
//   asyncIn  - level from another clock domain
//   syncOut  - synchronized level
module reset_lock_sync (
    input  logic clk,
    input  logic rstN,
    input  logic asyncIn,
    output logic syncOut
);

    logic meta;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meta    <= 1'b0;
            syncOut <= 1'b0;
        end else begin
            meta    <= asyncIn;
            syncOut <= meta;
        end
    end

endmodule

// File: rtl/global_reset_sequencer.sv
// Purpose: sequences per-domain reset release after PLL lock, with soft reset and lock-loss recovery.
// Latency: PLL lock change acts on the FSM two edges after it is sampled; all outputs are registered.
// Backpressure: none; soft-reset requests outside RUN are ignored, not queued.
//
// Ports:
//   iCLOCK           - 50 MHz main clock, rising edge
//   inRESET          - asynchronous active-low reset
//   iPLL_LOCK        - PLL locked flag, asynchronous to iCLOCK
//   iSOFT_RESET_REQ  - level-sampled soft-reset request, honoured only in RUN
//   onRESET_VGA/ASMI/MMC/MAIN - active-low domain resets, released in that order
//   oRESET_DONE      - high while every domain reset is released
//   oLOCK_LOSS_COUNT - saturating count of lock losses seen after WAIT_LOCK
module global_reset_sequencer
    import global_reset_pkg::*;
#(
    parameter int P_STABLE_CYCLES    = DEF_STABLE_CYCLES,
    parameter int P_STAGGER_CYCLES   = DEF_STAGGER_CYCLES,
    parameter int P_SOFT_HOLD_CYCLES = DEF_SOFT_HOLD_CYCLES
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iPLL_LOCK,
    input  logic       iSOFT_RESET_REQ,
    output logic       onRESET_VGA,
    output logic       onRESET_ASMI,
    output logic       onRESET_MMC,
    output logic       onRESET_MAIN,
    output logic       oRESET_DONE,
    output logic [7:0] oLOCK_LOSS_COUNT
);

    localparam int CNT_W = counterWidth(P_STABLE_CYCLES, P_STAGGER_CYCLES, P_SOFT_HOLD_CYCLES);

    // Counter values at which each event fires. The counter is cleared on
    // the entry edge, so an event N edges after entry fires at count N-1.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(P_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(P_SOFT_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ASMI_AT     = CNT_W'(P_STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] MMC_AT      = CNT_W'(2 * P_STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAIN_AT     = CNT_W'(3 * P_STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             sLock;
    seqState_t        state;
    logic [CNT_W-1:0] counter;

    reset_lock_sync uLockSync (
        .clk     (iCLOCK),
        .rstN    (inRESET),
        .asyncIn (iPLL_LOCK),
        .syncOut (sLock)
    );

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state            <= WAIT_LOCK;
            counter          <= '0;
            onRESET_VGA      <= 1'b0;
            onRESET_ASMI     <= 1'b0;
            onRESET_MMC      <= 1'b0;
            onRESET_MAIN     <= 1'b0;
            oRESET_DONE      <= 1'b0;
            oLOCK_LOSS_COUNT <= 8'd0;
        end else if (state != WAIT_LOCK && !sLock) begin
            // Lock loss outranks soft reset and any counter expiry.
            state        <= WAIT_LOCK;
            counter      <= '0;
            onRESET_VGA  <= 1'b0;
            onRESET_ASMI <= 1'b0;
            onRESET_MMC  <= 1'b0;
            onRESET_MAIN <= 1'b0;
            oRESET_DONE  <= 1'b0;
            if (oLOCK_LOSS_COUNT != 8'hFF) begin
                oLOCK_LOSS_COUNT <= oLOCK_LOSS_COUNT + 8'd1;
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    onRESET_VGA  <= 1'b0;
                    onRESET_ASMI <= 1'b0;
                    onRESET_MMC  <= 1'b0;
                    onRESET_MAIN <= 1'b0;
                    oRESET_DONE  <= 1'b0;
                    counter      <= '0;
                    if (sLock) begin
                        state <= STABILIZE;
                    end
                end

                STABILIZE: begin
                    if (counter == STABLE_LAST) begin
                        state       <= RELEASE;
                        counter     <= '0;
                        onRESET_VGA <= 1'b1;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end

                RELEASE: begin
                    if (counter == ASMI_AT) onRESET_ASMI <= 1'b1;
                    if (counter == MMC_AT)  onRESET_MMC  <= 1'b1;
                    if (counter == MAIN_AT) begin
                        onRESET_MAIN <= 1'b1;
                        oRESET_DONE  <= 1'b1;
                        state        <= RUN;
                        counter      <= '0;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end

                RUN: begin
                    counter <= '0;
                    if (iSOFT_RESET_REQ) begin
                        state        <= SOFT_HOLD;
                        onRESET_VGA  <= 1'b0;
                        onRESET_ASMI <= 1'b0;
                        onRESET_MMC  <= 1'b0;
                        onRESET_MAIN <= 1'b0;
                        oRESET_DONE  <= 1'b0;
                    end
                end

                SOFT_HOLD: begin
                    // PLL is still locked here, so skip straight to release.
                    if (counter == HOLD_LAST) begin
                        state       <= RELEASE;
                        counter     <= '0;
                        onRESET_VGA <= 1'b1;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end

                default: begin
                    state        <= WAIT_LOCK;
                    counter      <= '0;
                    onRESET_VGA  <= 1'b0;
                    onRESET_ASMI <= 1'b0;
                    onRESET_MMC  <= 1'b0;
                    onRESET_MAIN <= 1'b0;
                    oRESET_DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_global_reset_sequencer.sv
// Purpose: self-checking bench for global_reset_sequencer with directed and random lock/soft-reset traffic.
// Latency: checks outputs 1 ns after each rising edge against a timeline-based reference model.
// Backpressure: n/a.
module tb_global_reset_sequencer;

    localparam int STABLE = 8;
    localparam int STAG   = 4;
    localparam int HOLD   = 6;

    logic       clk     = 1'b0;
    logic       rstN    = 1'b1;
    logic       pllLock = 1'b0;
    logic       softReq = 1'b0;
    logic       rstVga, rstAsmi, rstMmc, rstMain, rstDone;
    logic [7:0] lossCount;

    int nChecks = 0;
    int nFails  = 0;

    global_reset_sequencer #(
        .P_STABLE_CYCLES    (STABLE),
        .P_STAGGER_CYCLES   (STAG),
        .P_SOFT_HOLD_CYCLES (HOLD)
    ) dut (
        .iCLOCK           (clk),
        .inRESET          (rstN),
        .iPLL_LOCK        (pllLock),
        .iSOFT_RESET_REQ  (softReq),
        .onRESET_VGA      (rstVga),
        .onRESET_ASMI     (rstAsmi),
        .onRESET_MMC      (rstMmc),
        .onRESET_MAIN     (rstMain),
        .oRESET_DONE      (rstDone),
        .oLOCK_LOSS_COUNT (lossCount)
    );

    always #10 clk = ~clk;

    wire [4:0] obsRst = {rstVga, rstAsmi, rstMmc, rstMain, rstDone};

    // Reference model: a timeline of when the sequence armed, released or
    // entered a soft hold. Output levels are derived from elapsed edges.
    bit         lockQ[$];   // lock samples still travelling to the FSM
    int         edgeNo;
    int         armedAt, releaseAt, holdAt, lossCnt;
    logic [4:0] expRst;

    task automatic modelReset();
        lockQ     = {1'b0, 1'b0};
        armedAt   = -1;
        releaseAt = -1;
        holdAt    = -1;
        lossCnt   = 0;
        expRst    = '0;
    endtask

    task automatic tick();
        bit fsmLock;
        bit idle;
        int k;
        @(posedge clk);
        k = edgeNo;
        edgeNo++;
        lockQ.push_back(pllLock);
        fsmLock = lockQ.pop_front();
        idle = (armedAt < 0) && (releaseAt < 0) && (holdAt < 0);
        if (!idle && !fsmLock) begin
            if (lossCnt < 255) lossCnt++;
            armedAt = -1; releaseAt = -1; holdAt = -1;
        end else if (idle) begin
            if (fsmLock) armedAt = k;
        end else if (armedAt >= 0) begin
            if (k == armedAt + STABLE) begin releaseAt = k; armedAt = -1; end
        end else if (holdAt >= 0) begin
            if (k == holdAt + HOLD) begin releaseAt = k; holdAt = -1; end
        end else if (k > releaseAt + 3 * STAG && softReq) begin
            holdAt = k; releaseAt = -1;
        end
        if (releaseAt >= 0)
            expRst = {1'b1, k >= releaseAt + STAG, k >= releaseAt + 2 * STAG,
                      k >= releaseAt + 3 * STAG, k >= releaseAt + 3 * STAG};
        else
            expRst = '0;
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rstN = 1'b0; pllLock = 1'b0; softReq = 1'b0;
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        #3 rstN = 1'b0;
        modelReset();
        #2;
        nChecks++;
        if (obsRst !== 5'b0 || lossCount !== 8'd0) begin
            nFails++;
            $display("FAIL reset_async: got rst=%b cnt=%0d, expected rst=00000 cnt=0", obsRst, lossCount);
        end
        pllLock = 1'b1;
        repeat (4) tick();
        nChecks++;
        if (obsRst !== 5'b0 || lossCount !== 8'd0) begin
            nFails++;
            $display("FAIL reset_held: got rst=%b cnt=%0d, expected rst=00000 cnt=0", obsRst, lossCount);
        end
        applyReset();
        for (int e = 0; e < 10; e++) begin
            tick();
            nChecks++;
            if (obsRst !== 5'b0) begin
                nFails++;
                $display("FAIL wait_lock edge %0d: got rst=%b, expected rst=00000", e, obsRst);
            end
        end
    endtask

    task automatic test_power_up_and_soft();
        logic [4:0] want;
        applyReset();
        for (int e = 0; e <= 50; e++) begin
            pllLock = 1'b1;
            softReq = (e == 30);
            tick();
            softReq = 1'b0;
            if (e < 30) want = {e >= 10, e >= 14, e >= 18, e >= 22, e >= 22};
            else        want = {e >= 36, e >= 40, e >= 44, e >= 48, e >= 48};
            nChecks++;
            if (obsRst !== want || lossCount !== 8'd0) begin
                nFails++;
                $display("FAIL power_up_soft edge %0d: got rst=%b cnt=%0d, expected rst=%b cnt=0",
                         e, obsRst, lossCount, want);
            end
        end
    endtask

    task automatic test_lock_drop_release();
        logic [4:0] want;
        logic [7:0] wantCnt;
        applyReset();
        for (int e = 0; e <= 40; e++) begin
            pllLock = !(e >= 12 && e <= 14);
            tick();
            if (e >= 10 && e < 14)
                want = 5'b10000;
            else if (e >= 25)
                want = {1'b1, e >= 29, e >= 33, e >= 37, e >= 37};
            else
                want = 5'b00000;
            wantCnt = (e >= 14) ? 8'd1 : 8'd0;
            nChecks++;
            if (obsRst !== want || lossCount !== wantCnt) begin
                nFails++;
                $display("FAIL lock_drop_release edge %0d: got rst=%b cnt=%0d, expected rst=%b cnt=%0d",
                         e, obsRst, lossCount, want, wantCnt);
            end
        end
    endtask

    task automatic test_reset_mid_stabilize();
        logic [4:0] want;
        // Short lock dropout from RUN: one loss, then re-arm into STABILIZE.
        pllLock = 1'b0;
        tick();
        pllLock = 1'b1;
        repeat (5) tick();
        nChecks++;
        if (obsRst !== 5'b0 || lossCount !== 8'd2) begin
            nFails++;
            $display("FAIL stabilize_entry: got rst=%b cnt=%0d, expected rst=00000 cnt=2", obsRst, lossCount);
        end
        #2 rstN = 1'b0;
        modelReset();
        #1;
        nChecks++;
        if (obsRst !== 5'b0 || lossCount !== 8'd0) begin
            nFails++;
            $display("FAIL reset_mid_stabilize: got rst=%b cnt=%0d, expected rst=00000 cnt=0", obsRst, lossCount);
        end
        @(negedge clk);
        rstN = 1'b1;
        for (int e = 0; e <= 24; e++) begin
            tick();
            want = {e >= 10, e >= 14, e >= 18, e >= 22, e >= 22};
            nChecks++;
            if (obsRst !== want || lossCount !== 8'd0) begin
                nFails++;
                $display("FAIL restart edge %0d: got rst=%b cnt=%0d, expected rst=%b cnt=0",
                         e, obsRst, lossCount, want);
            end
        end
    endtask

    task automatic test_drop_and_soft_same_edge();
        // Entered in RUN with count 0: lock sampled low at edge 0 reaches the
        // FSM at edge 2, the same edge the soft request is presented.
        pllLock = 1'b0;
        tick();
        tick();
        nChecks++;
        if (obsRst !== 5'b11111 || lossCount !== 8'd0) begin
            nFails++;
            $display("FAIL drop_soft_pre: got rst=%b cnt=%0d, expected rst=11111 cnt=0", obsRst, lossCount);
        end
        softReq = 1'b1;
        tick();
        softReq = 1'b0;
        nChecks++;
        if (obsRst !== 5'b0 || lossCount !== 8'd1) begin
            nFails++;
            $display("FAIL drop_soft_edge: got rst=%b cnt=%0d, expected rst=00000 cnt=1", obsRst, lossCount);
        end
        for (int e = 3; e <= 12; e++) begin
            tick();
            nChecks++;
            if (obsRst !== 5'b0 || lossCount !== 8'd1) begin
                nFails++;
                $display("FAIL drop_soft_hold edge %0d: got rst=%b cnt=%0d, expected rst=00000 cnt=1",
                         e, obsRst, lossCount);
            end
        end
    endtask

    task automatic test_saturation();
        int want;
        applyReset();
        for (int i = 0; i < 300; i++) begin
            pllLock = 1'b1;
            tick();
            pllLock = 1'b0;
            tick();
            want = (i < 255) ? i : 255;
            nChecks++;
            if (lossCount !== 8'(want)) begin
                nFails++;
                $display("FAIL saturation pulse %0d: got cnt=%0d, expected cnt=%0d", i, lossCount, want);
            end
        end
        repeat (3) tick();
        nChecks++;
        if (lossCount !== 8'd255 || obsRst !== 5'b0) begin
            nFails++;
            $display("FAIL saturation_final: got cnt=%0d rst=%b, expected cnt=255 rst=00000", lossCount, obsRst);
        end
    endtask

    task automatic test_random();
        int runLeft;
        applyReset();
        runLeft = 0;
        for (int n = 0; n < 4000; n++) begin
            if (runLeft == 0) begin
                pllLock = ~pllLock;
                runLeft = pllLock ? $urandom_range(1, 80) : $urandom_range(1, 8);
            end
            runLeft--;
            softReq = ($urandom_range(0, 15) == 0);
            tick();
            nChecks++;
            if (obsRst !== expRst || lossCount !== 8'(lossCnt)) begin
                nFails++;
                $display("FAIL random cycle %0d: got rst=%b cnt=%0d, expected rst=%b cnt=%0d",
                         n, obsRst, lossCount, expRst, lossCnt);
            end
            if ($urandom_range(0, 499) == 0) begin
                rstN = 1'b0;
                modelReset();
                #1;
                nChecks++;
                if (obsRst !== 5'b0 || lossCount !== 8'd0) begin
                    nFails++;
                    $display("FAIL random_reset cycle %0d: got rst=%b cnt=%0d, expected rst=00000 cnt=0",
                             n, obsRst, lossCount);
                end
                #2 rstN = 1'b1;
            end
        end
        softReq = 1'b0;
    endtask

    initial begin
        edgeNo = 0;
        modelReset();
        test_reset();
        test_power_up_and_soft();
        test_lock_drop_release();
        test_reset_mid_stabilize();
        test_drop_and_soft_same_edge();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/global_reset_sequencer.md
GLOBAL_RESET_SEQUENCER -- requirements
Module: global_reset_sequencer

Interface
REQ-001 Parameter P_STABLE_CYCLES, default 1024, PLL lock stabilisation time in iCLOCK cycles (>=2).
REQ-002 Parameter P_STAGGER_CYCLES, default 16, spacing between successive domain reset releases (>=1).
REQ-003 Parameter P_SOFT_HOLD_CYCLES, default 64, reset assertion time for a soft reset (>=1).
REQ-004 iCLOCK  input  1  single clock, 50 MHz main clock; all logic on rising edge.
REQ-005 inRESET  input  1  asynchronous, active-low reset.
REQ-006 iPLL_LOCK  input  1  PLL locked flag, asynchronous to iCLOCK.
REQ-007 iSOFT_RESET_REQ  input  1  synchronous soft-reset request, level-sampled.
REQ-008 onRESET_VGA  output  1  active-low reset request, VGA domain.
REQ-009 onRESET_ASMI  output  1  active-low reset request, ASMI domain.
REQ-010 onRESET_MMC  output  1  active-low reset request, MMC domain.
REQ-011 onRESET_MAIN  output  1  active-low reset request, main domain.
REQ-012 oRESET_DONE  output  1  high while all domain resets are released.
REQ-013 oLOCK_LOSS_COUNT  output  8  saturating count of lock-loss events.

Function
REQ-014 iPLL_LOCK SHALL pass through a 2-flop synchronizer; FSM uses only the synchronized value (s_lock).
REQ-015 FSM states: WAIT_LOCK, STABILIZE, RELEASE, RUN, SOFT_HOLD; one shared cycle counter, cleared on every state entry.
REQ-016 WAIT_LOCK: all four reset outputs 0, oRESET_DONE 0; s_lock=1 -> STABILIZE.
REQ-017 STABILIZE: counter increments each cycle; at counter==P_STABLE_CYCLES-1 -> RELEASE.
REQ-018 RELEASE: onRESET_VGA goes 1 on the entry edge; onRESET_ASMI goes 1 P_STAGGER_CYCLES edges later, onRESET_MMC 2*P_STAGGER_CYCLES later, onRESET_MAIN and oRESET_DONE 3*P_STAGGER_CYCLES later, on the same edge as entry to RUN.
REQ-019 Released outputs SHALL stay 1 until a lock loss, soft reset or inRESET; no glitches (all outputs registered).
REQ-020 RUN: iSOFT_RESET_REQ=1 -> SOFT_HOLD; all resets and oRESET_DONE go 0 on that edge.
REQ-021 SOFT_HOLD: hold P_SOFT_HOLD_CYCLES cycles, then -> RELEASE (no STABILIZE); iSOFT_RESET_REQ ignored outside RUN.
REQ-022 s_lock=0 in any state except WAIT_LOCK -> WAIT_LOCK; all resets and oRESET_DONE 0 on that edge; takes priority over soft reset and counter expiry.
REQ-023 Each such transition SHALL increment oLOCK_LOSS_COUNT by 1, saturating at 255; no wrap.
REQ-024 Latency: iPLL_LOCK change sampled at edge N acts on FSM at edge N+2; lock pulses shorter than one iCLOCK period may be missed.

Reset
REQ-025 inRESET=0 SHALL asynchronously force state WAIT_LOCK, counter 0, synchronizer flops 0, all onRESET_* 0, oRESET_DONE 0, oLOCK_LOSS_COUNT 0.
REQ-026 inRESET deassertion mid-sequence SHALL restart from WAIT_LOCK; no partial release survives.

Structure
REQ-027 Shared package global_reset_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-028 Synchronizer SHALL be a sub-module reset_lock_sync (2-flop, async active-low clear).
REQ-029 Counter width SHALL be derived from the largest of the three parameters.

Verification (P_STABLE=8, P_STAGGER=4, P_SOFT_HOLD=6)
REQ-030 Lock rise sampled edge 0 -> STABILIZE edge 2; VGA=1 edge 10, ASMI=1 edge 14, MMC=1 edge 18, MAIN=1 and DONE=1 edge 22.
REQ-031 In RUN, iSOFT_RESET_REQ=1 one cycle at edge 30 -> all resets 0 edge 30; VGA=1 edge 36, MAIN/DONE=1 edge 48; count unchanged.
REQ-032 Lock drop sampled during RELEASE (after VGA=1) -> all 0 two edges later, count=1; lock return -> full sequence again from STABILIZE.
REQ-033 300 lock-loss events -> oLOCK_LOSS_COUNT holds 255.
REQ-034 inRESET pulsed low mid-STABILIZE -> immediate all-zero outputs, count=0, sequence restarts from WAIT_LOCK.
REQ-035 Lock drop and iSOFT_RESET_REQ seen on the same edge in RUN -> WAIT_LOCK (not SOFT_HOLD), count incremented.
